xy_arb: RTL
===========

# xy_arb

Arbiter and sequencer for the shared x/y increment datapath. Two requesters, X and Y, each hand in an operand over a valid/ready handshake. The block grants one requester at a time by round-robin, drives the load/select/write-back controls of a single incrementer, and returns `operand + 1` to the granted side over a response handshake. It sits between the requesting blocks and the incrementer datapath, replacing the fixed 4-phase state counter that sequenced that datapath.

## Interface
- `WIDTH`, default 4: operand/result width.
- `CNT_W`, default 8: width of the per-side service counters.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_x_valid`  in  1  X has an operand.
- `req_x_data`  in  WIDTH  X operand.
- `req_x_ready`  out  1  X operand accepted this cycle.
- `req_y_valid`, `req_y_data`, `req_y_ready`: same as the X signals, for Y.
- `rsp_x_valid`  out  1  X result available.
- `rsp_x_data`  out  WIDTH  X result.
- `rsp_x_wrap`  out  1  X result wrapped (operand was all ones).
- `rsp_x_ready`  in  1  X consumer takes the result.
- `rsp_y_valid`, `rsp_y_data`, `rsp_y_wrap`, `rsp_y_ready`: same as the X signals, for Y.
- `busy`  out  1  state is not IDLE.
- `served_x`, `served_y`  out  CNT_W  completed transactions per side; saturating.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - Arbitration is combinational. If only one side is valid, grant that side. If both are valid, grant the side not in `last_grant`.
  - Assert `ready` to the granted side only. On the handshake, load the operand register, record `grant`, update `last_grant`, and go to EXEC.
  - With no request, stay in IDLE and keep both readys low.
- **EXEC:**
  - Compute `value = operand + 1`, modulo 2^WIDTH.
  - Carry-out sets the wrap flag. Example: 4'hF gives 4'h0 with wrap = 1.
  - Write `value` and the wrap flag into the result register of the granted side only. Go to RESP.
- **RESP:**
  - Hold the granted side's `rsp_valid` high with data and wrap stable.
  - On `rsp_valid && rsp_ready`: clear `rsp_valid`, increment that side's `served` counter (saturates at 2^CNT_W−1, never wraps), and go to IDLE.
- The non-granted side's result register and `rsp_valid` never change during a transaction.
- At most one transaction is in flight. `req_*_ready` is low in EXEC and RESP.
- Requester rule: once `valid` is high, `valid` and `data` stay stable until `ready`. Consumer rule: `rsp_ready` may be high at any time; the block ignores it while its `rsp_valid` is low.
- Simultaneous events:
  - Both valid in IDLE: exactly one ready goes high.
  - A request arriving in EXEC or RESP waits and is arbitrated in the next IDLE.
- **Reset** (asserted at any time, including mid-transaction): immediately abandon the transaction.
  - State goes to IDLE and `last_grant` = Y, so X wins the first tie.
  - Clear the operand register, result registers, wrap flags, `rsp_*_valid`, counters and `busy`. All outputs read 0 while reset is asserted.
  - Deassertion is synchronised externally; no transaction starts in the reset-release cycle unless a request is already valid.

## Timing
- Cycle t: request accepted (`valid && ready` in IDLE).
- Cycle t+1: EXEC. Result register written at the end of this cycle.
- Cycle t+2: `rsp_valid` high (RESP).
- If `rsp_ready` is high at t+2, the block is back in IDLE at t+3. Back-to-back acceptances are therefore 3 cycles apart at best.
- `req_*_ready` is combinational from `req_*_valid`, state and `last_grant`. All other outputs are registered.
- `busy` is registered and equals `state != IDLE`.

## Structure
- Package `xy_pkg`:
  - State typedef `xy_state_t` (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
  - Side typedef `xy_side_t` (SIDE_X=1'b0, SIDE_Y=1'b1).
  - Reset constant `XY_LAST_GRANT_RST = SIDE_Y`.
- Sub-module `xy_incr_dp` contains:
  - operand register with `load`;
  - `WIDTH+1` incrementer;
  - two result+wrap registers, written by `load_x`/`load_y`.
  
  The controller drives these controls; the FSM, arbiter and counters stay in the `xy_arb` top.

## Test plan
- **Single X request:** `req_x_data=4'h3` held valid → `req_x_ready` at t; `rsp_x_valid` at t+2 with `rsp_x_data=4'h4`, `rsp_x_wrap=0`; `served_x=1`; all Y outputs stay 0.
- **Wrap:** Y sends 4'hF → `rsp_y_data=4'h0`, `rsp_y_wrap=1`.
- **Contention:** X and Y both valid continuously, with operands 1 and 7, `rsp_ready` always high → grants alternate X, Y, X, Y starting with X; acceptances 3 cycles apart; responses 2 and 8 on the matching sides.
- **Backpressure:** `rsp_x_ready` low for 5 cycles while Y is valid → `rsp_x_valid` and data held stable; `req_y_ready` stays low until 1 cycle after `rsp_x_ready` rises.
- **Reset mid-transaction:** reset asserted during EXEC → all outputs 0 immediately; after release a held X request is accepted first, and the earlier abandoned X result never appears.
- **Saturation** (`CNT_W=2`): 5 X transactions → `served_x` counts 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/xy_pkg.sv
// xy_pkg
// Shared types and constants for the x/y increment arbiter.
//   xy_state_t        : controller states (IDLE, EXEC, RESP)
//   xy_side_t         : requester identity (SIDE_X, SIDE_Y)
//   XY_LAST_GRANT_RST : last_grant value after reset; Y so that X wins
//                       the first tie.
package xy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } xy_state_t;

  typedef enum logic {
    SIDE_X = 1'b0,
    SIDE_Y = 1'b1
  } xy_side_t;

  localparam xy_side_t XY_LAST_GRANT_RST = SIDE_Y;

endpackage

// File: rtl/xy_incr_dp.sv
// xy_incr_dp
// Incrementer datapath shared by the X and Y requesters.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   load, operand_in : capture a new operand into the operand register
//   load_x, load_y   : write operand+1 and its carry into the X / Y
//                      result registers
//   res_x, wrap_x    : X result register and wrap flag
//   res_y, wrap_y    : Y result register and wrap flag
module xy_incr_dp #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] operand_in,
  input  logic             load_x,
  input  logic             load_y,
  output logic [WIDTH-1:0] res_x,
  output logic             wrap_x,
  output logic [WIDTH-1:0] res_y,
  output logic             wrap_y
);

  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   sum;

  // One extra bit on the adder so the carry-out becomes the wrap flag.
  assign sum = {1'b0, operand} + (WIDTH+1)'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      operand <= '0;
    end else if (load) begin
      operand <= operand_in;
    end
  end

  // Each result register only moves when its own side is being served,
  // so the idle side keeps presenting its previous result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_x  <= '0;
      wrap_x <= 1'b0;
      res_y  <= '0;
      wrap_y <= 1'b0;
    end else begin
      if (load_x) begin
        res_x  <= sum[WIDTH-1:0];
        wrap_x <= sum[WIDTH];
      end
      if (load_y) begin
        res_y  <= sum[WIDTH-1:0];
        wrap_y <= sum[WIDTH];
      end
    end
  end

endmodule

// File: rtl/xy_arb.sv
// xy_arb
// Round-robin arbiter and sequencer for the shared x/y incrementer.
// Ports:
//   clk, rst                            : clock, asynchronous active-low reset
//   req_{x,y}_valid/data/ready          : operand request handshake
//   rsp_{x,y}_valid/data/wrap/ready     : result response handshake
//   busy                                : controller is not in IDLE
//   served_x, served_y                  : saturating completed-transaction counts
module xy_arb #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_x_valid,
  input  logic [WIDTH-1:0] req_x_data,
  output logic             req_x_ready,
  input  logic             req_y_valid,
  input  logic [WIDTH-1:0] req_y_data,
  output logic             req_y_ready,
  output logic             rsp_x_valid,
  output logic [WIDTH-1:0] rsp_x_data,
  output logic             rsp_x_wrap,
  input  logic             rsp_x_ready,
  output logic             rsp_y_valid,
  output logic [WIDTH-1:0] rsp_y_data,
  output logic             rsp_y_wrap,
  input  logic             rsp_y_ready,
  output logic             busy,
  output logic [CNT_W-1:0] served_x,
  output logic [CNT_W-1:0] served_y
);

  import xy_pkg::*;

  xy_state_t        state;
  xy_side_t         grant;
  xy_side_t         last_grant;
  logic             accept;
  xy_side_t         accept_side;
  logic [WIDTH-1:0] operand_in;
  logic             load_x;
  logic             load_y;
  logic             rsp_done;

  // Arbitration: a lone requester wins outright; on a tie the side that was
  // not served last wins. Ready is gated by reset so every output reads 0
  // while reset is held, even with a request pending.
  always_comb begin
    req_x_ready = 1'b0;
    req_y_ready = 1'b0;
    if (rst && state == IDLE) begin
      if (req_x_valid && req_y_valid) begin
        if (last_grant == SIDE_Y) begin
          req_x_ready = 1'b1;
        end else begin
          req_y_ready = 1'b1;
        end
      end else begin
        req_x_ready = req_x_valid;
        req_y_ready = req_y_valid;
      end
    end
  end

  assign accept      = req_x_ready | req_y_ready;
  assign accept_side = req_y_ready ? SIDE_Y : SIDE_X;
  assign operand_in  = req_y_ready ? req_y_data : req_x_data;
  assign load_x      = (state == EXEC) && (grant == SIDE_X);
  assign load_y      = (state == EXEC) && (grant == SIDE_Y);

  // Only the granted side's consumer can close the transaction.
  assign rsp_done = (state == RESP) &&
                    (((grant == SIDE_X) && rsp_x_ready) ||
                     ((grant == SIDE_Y) && rsp_y_ready));

  xy_incr_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .operand_in (operand_in),
    .load_x     (load_x),
    .load_y     (load_y),
    .res_x      (rsp_x_data),
    .wrap_x     (rsp_x_wrap),
    .res_y      (rsp_y_data),
    .wrap_y     (rsp_y_wrap)
  );

  // Controller: one transaction at a time, IDLE -> EXEC -> RESP -> IDLE.
  // busy, response valids and service counters are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= SIDE_X;
      last_grant  <= XY_LAST_GRANT_RST;
      busy        <= 1'b0;
      rsp_x_valid <= 1'b0;
      rsp_y_valid <= 1'b0;
      served_x    <= '0;
      served_y    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= EXEC;
            grant      <= accept_side;
            last_grant <= accept_side;
            busy       <= 1'b1;
          end
        end
        EXEC: begin
          state <= RESP;
          if (grant == SIDE_X) begin
            rsp_x_valid <= 1'b1;
          end else begin
            rsp_y_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (grant == SIDE_X) begin
              rsp_x_valid <= 1'b0;
              if (served_x != {CNT_W{1'b1}}) begin
                served_x <= served_x + CNT_W'(1);
              end
            end else begin
              rsp_y_valid <= 1'b0;
              if (served_y != {CNT_W{1'b1}}) begin
                served_y <= served_y + CNT_W'(1);
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
